// File: rtl/mem_port_arb.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise the data stage always wins.
module mem_port_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic [DATA_W-1:0]     o_if_rdata,
    output logic                  o_if_valid,
    output logic                  o_if_stall,
    input  logic                  i_dm_req,
    input  logic                  i_dm_wen,
    input  logic [ADDR_W-1:0]     i_dm_addr,
    input  logic [DATA_W-1:0]     i_dm_wdata,
    input  logic [DATA_W/8-1:0]   i_dm_mask,
    output logic [DATA_W-1:0]     o_dm_rdata,
    output logic                  o_dm_valid,
    output logic                  o_dm_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_wen,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_mask,
    input  logic                  i_mem_ack,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic                mem_wen_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_mask_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic                if_valid_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                dm_valid_q;

    logic if_elig_s;
    logic dm_elig_s;
    logic grant_dm_s;

    // A requester still high in its own completion cycle is not eligible again yet.
    assign if_elig_s = i_if_req & ~if_valid_q;
    assign dm_elig_s = i_dm_req & ~dm_valid_q;

`ifdef MEM_ARB_RR_EN
    logic last_dm_q;
    assign grant_dm_s = dm_elig_s & (~if_elig_s | ~last_dm_q);
`else
    assign grant_dm_s = dm_elig_s;
`endif

    assign o_if_stall  = i_if_req & ~if_valid_q;
    assign o_dm_stall  = i_dm_req & ~dm_valid_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_mask  = mem_mask_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_if_valid  = if_valid_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_dm_valid  = dm_valid_q;

    // Arbitration FSM with registered memory-side and completion outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm_q   <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dm_s) begin
                        state_q     <= BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= i_dm_wen;
                        mem_addr_q  <= i_dm_addr;
                        mem_wdata_q <= i_dm_wdata;
                        mem_mask_q  <= i_dm_mask;
                    end else if (if_elig_s) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_wen_q   <= 1'b0;
                        mem_addr_q  <= i_if_addr;
                        mem_wdata_q <= '0;
                        mem_mask_q  <= {MASK_W{1'b1}};
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY_IF: begin
                    if (i_mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_rdata_q <= i_mem_rdata;
                        if_valid_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_dm_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= BUSY_IF;
                    end
                end
                BUSY_DM: begin
                    if (i_mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        dm_valid_q <= 1'b1;
                        if (!mem_wen_q) begin
                            dm_rdata_q <= i_mem_rdata;
                        end else begin
                            dm_rdata_q <= dm_rdata_q;
                        end
`ifdef MEM_ARB_RR_EN
                        last_dm_q  <= 1'b1;
`endif
                    end else begin
                        state_q <= BUSY_DM;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
